// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured parallel pattern out MSB-first on w,
// optionally repeating it with a fixed idle gap between passes.
module pattern_tx #(
    parameter int WIDTH      = 8,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       State
);

    localparam int BIT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             cur_state, nxt_state;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [WIDTH-1:0]   hold, hold_n;
    logic [BIT_W-1:0]   bitcnt, bitcnt_n;
    logic [REP_W-1:0]   passcnt, passcnt_n;
    logic [GAP_W-1:0]   gapcnt, gapcnt_n;
    logic               w_n, w_valid_n, busy_n, done_n;

    assign State = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            bitcnt    <= '0;
            passcnt   <= '0;
            gapcnt    <= '0;
            w         <= 1'b0;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            shreg     <= shreg_n;
            hold      <= hold_n;
            bitcnt    <= bitcnt_n;
            passcnt   <= passcnt_n;
            gapcnt    <= gapcnt_n;
            w         <= w_n;
            w_valid   <= w_valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        shreg_n   = shreg;
        hold_n    = hold;
        bitcnt_n  = bitcnt;
        passcnt_n = passcnt;
        gapcnt_n  = gapcnt;

        case (cur_state)
            IDLE: begin
                if (start) begin
                    shreg_n   = pattern;
                    hold_n    = pattern;
                    passcnt_n = repeat_cnt;
                    bitcnt_n  = BIT_W'(WIDTH - 1);
                    nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    nxt_state = IDLE;
                end else if (bitcnt == '0) begin
                    if (passcnt == '0) begin
                        nxt_state = DONE;
                    end else begin
                        // Reload here so the next pass is ready whether or not a gap follows.
                        passcnt_n = passcnt - 1'b1;
                        shreg_n   = hold;
                        bitcnt_n  = BIT_W'(WIDTH - 1);
                        gapcnt_n  = GAP_W'(GAP_LOAD);
                        nxt_state = (GAP_CYCLES == 0) ? SHIFT : GAP;
                    end
                end else begin
                    shreg_n  = {shreg[WIDTH-2:0], 1'b0};
                    bitcnt_n = bitcnt - 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    nxt_state = IDLE;
                end else if (gapcnt == '0) begin
                    nxt_state = SHIFT;
                end else begin
                    gapcnt_n = gapcnt - 1'b1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with State.
    always_comb begin
        w_n       = 1'b0;
        w_valid_n = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        case (nxt_state)
            SHIFT: begin
                w_n       = shreg_n[WIDTH-1];
                w_valid_n = 1'b1;
                busy_n    = 1'b1;
            end
            GAP:     busy_n = 1'b1;
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: scoreboard of expected serial bits plus
// directed checks of State/busy/done timing, abort, async reset and repeat limits.
module tb_pattern_tx;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, start0, abort;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] repeat_cnt;
    logic             w, w_valid, busy, done;
    logic [1:0]       State;
    logic             w0, w_valid0, busy0, done0;
    logic [1:0]       State0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned done_cnt, busy_cnt, valid_cnt, done0_cnt, valid0_cnt;
    logic        sb[$];

    always #5 clk = ~clk;

    pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .repeat_cnt(repeat_cnt),
        .w(w), .w_valid(w_valid), .busy(busy), .done(done), .State(State)
    );

    pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort),
        .pattern(pattern), .repeat_cnt(repeat_cnt),
        .w(w0), .w_valid(w_valid0), .busy(busy0), .done(done0), .State(State0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [WIDTH-1:0] p);
        for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(p[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer and activity counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (w_valid) begin
            if (sb.size() == 0) check_eq("sb_extra_bit", w_valid, 1'b0);
            else check_eq("sb_bit", w, sb.pop_front());
        end
        done_cnt   += done;
        busy_cnt   += busy;
        valid_cnt  += w_valid;
        done0_cnt  += done0;
        valid0_cnt += w_valid0;
    end

    initial begin
        logic [15:0] exp16;
        reset = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0;
        pattern = '0; repeat_cnt = '0;
        done_cnt = 0; busy_cnt = 0; valid_cnt = 0; done0_cnt = 0; valid0_cnt = 0;
        repeat (2) tick();
        check_eq("rst_state", State, 2'b00);
        check_eq("rst_w", {w, w_valid, busy, done}, 4'b0000);
        reset = 1'b0;
        tick();

        // 1: single pass, latency and done timing
        pattern = 8'b0011_0011; repeat_cnt = 0; push_bits(pattern);
        start = 1'b1; tick(); start = 1'b0;
        check_eq("t1_state_e0", State, 2'b01);
        check_eq("t1_vb_e0", {w_valid, busy, done}, 3'b110);
        repeat (7) tick();
        check_eq("t1_state_e7", State, 2'b01);
        tick();
        check_eq("t1_state_e8", State, 2'b11);
        check_eq("t1_done_e8", {done, busy, w_valid, w}, 4'b1000);
        tick();
        check_eq("t1_state_e9", State, 2'b00);
        check_eq("t1_done_e9", done, 1'b0);

        // 2: three passes with a 2-cycle gap
        done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        pattern = 8'hA5; repeat_cnt = 2;
        repeat (3) push_bits(pattern);
        start = 1'b1; tick(); start = 1'b0;
        repeat (34) tick();
        check_eq("t2_busy_cycles", busy_cnt, 28);
        check_eq("t2_valid_cycles", valid_cnt, 24);
        check_eq("t2_done_pulses", done_cnt, 1);

        // 3: back-to-back passes without a gap
        pattern = 8'hF0; repeat_cnt = 1; exp16 = 16'hF0F0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            check_eq("t3_valid", w_valid0, 1'b1);
            check_eq("t3_bit", w0, exp16[i]);
            tick();
        end
        check_eq("t3_done", {done0, State0}, 3'b111);

        // 4: abort on the 4th bit of pass 1, then a clean restart
        tick(); done_cnt = 0;
        pattern = 8'h96; repeat_cnt = 3;
        sb.push_back(1'b1); sb.push_back(1'b0); sb.push_back(1'b0); sb.push_back(1'b1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("t4_abort_state", State, 2'b00);
        check_eq("t4_abort_out", {w_valid, busy, done}, 3'b000);
        repeat (10) tick();
        check_eq("t4_no_done", done_cnt, 0);
        pattern = 8'h5C; repeat_cnt = 0; push_bits(pattern);
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        check_eq("t4_restart_done", done_cnt, 1);

        // 5: abort coinciding with the final bit wins over done
        done_cnt = 0;
        pattern = 8'h81; repeat_cnt = 0; push_bits(pattern);
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("t5_abort_last_state", State, 2'b00);
        repeat (3) tick();
        check_eq("t5_abort_last_done", done_cnt, 0);

        // 6: maximum repeat count gives 2^REP_W passes
        done0_cnt = 0; valid0_cnt = 0;
        pattern = 8'h3A; repeat_cnt = '1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        repeat (140) tick();
        check_eq("t6_max_valid", valid0_cnt, 128);
        check_eq("t6_max_done", done0_cnt, 1);

        // 7: async reset in the middle of a gap
        done_cnt = 0;
        pattern = 8'hA5; repeat_cnt = 1; repeat (2) push_bits(pattern);
        start = 1'b1; tick(); start = 1'b0;
        repeat (8) tick();
        check_eq("t7_in_gap", State, 2'b10);
        #2 reset = 1'b1;
        #1;
        check_eq("t7_async_state", State, 2'b00);
        check_eq("t7_async_out", {busy, w_valid, done}, 3'b000);
        sb.delete();
        tick(); reset = 1'b0;
        repeat (20) tick();
        check_eq("t7_no_done", done_cnt, 0);
        check_eq("t7_idle", State, 2'b00);

        // 8: start held high, pattern changed mid-pass
        done_cnt = 0;
        pattern = 8'hC3; repeat_cnt = 0; push_bits(pattern);
        start = 1'b1; tick();
        tick();
        pattern = 8'h3C; push_bits(pattern);
        repeat (7) tick();
        check_eq("t8_done_state", State, 2'b11);
        tick();
        check_eq("t8_idle_gap", State, 2'b00);
        tick();
        check_eq("t8_retrigger", State, 2'b01);
        start = 1'b0;
        repeat (10) tick();
        check_eq("t8_done_pulses", done_cnt, 2);

        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
